// File: rtl/relobi_pkg.sv
// Shared types and helpers for the reliable OBI credit scheduler.
package relobi_pkg;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  // Width needed to hold an outstanding count from 0 up to max_trans.
  function automatic int unsigned relobi_credit_cnt_width(input int unsigned max_trans);
    return (max_trans < 1) ? 1 : $clog2(max_trans + 1);
  endfunction

endpackage

// File: rtl/relobi_credit_counter.sv
// Single outstanding-transaction counter: up on grant, down on retire, saturating both ways.
module relobi_credit_counter #(
  parameter int unsigned CntWidth = 3,
  parameter int unsigned MaxVal   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                dec,
  output logic [CntWidth-1:0] cnt,
  output logic                underflow_c,
  output logic                overflow_c
);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                do_dec;

  // A retire against an empty counter is dropped rather than wrapping.
  always_comb begin
    cnt_d       = cnt_q;
    underflow_c = dec && (cnt_q == '0);
    do_dec      = dec && !underflow_c;
    overflow_c  = inc && !do_dec && (cnt_q >= CntWidth'(MaxVal));
    case ({inc, do_dec})
      2'b10:   if (!overflow_c) cnt_d = cnt_q + CntWidth'(1);
      2'b01:   cnt_d = cnt_q - CntWidth'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/relobi_mux_credit_arb.sv
// Credit-based round-robin issue scheduler in front of the reliable OBI mux.
// Enforces per-port and global outstanding limits and holds a pending request until granted.
module relobi_mux_credit_arb
  import relobi_pkg::*;
#(
  parameter int unsigned NumSbrPorts = 2,
  parameter int unsigned NumMaxTrans = 4,
  parameter int unsigned CntWidth    = relobi_credit_cnt_width(NumMaxTrans),
  parameter int unsigned IdxWidth    = $clog2(NumSbrPorts)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumSbrPorts*CntWidth-1:0] cfg_limit_i,
  input  logic [NumSbrPorts-1:0]          sbr_req_i,
  output logic [NumSbrPorts-1:0]          sbr_gnt_o,
  output logic                            mgr_req_o,
  input  logic                            mgr_gnt_i,
  output logic [IdxWidth-1:0]             sel_idx_o,
  input  logic                            rsp_valid_i,
  input  logic                            rsp_ready_i,
  input  logic [IdxWidth-1:0]             rsp_idx_i,
  output logic [NumSbrPorts*CntWidth-1:0] outst_o,
  output logic                            fault_o
);

  localparam int unsigned TotWidth = $clog2(NumSbrPorts * NumMaxTrans + 1);
  localparam int unsigned LastPort = NumSbrPorts - 1;

  if (NumSbrPorts < 2) begin : g_bad_ports
    $fatal(1, "relobi_mux_credit_arb: NumSbrPorts must be >= 2");
  end
  if (NumMaxTrans < 1) begin : g_bad_trans
    $fatal(1, "relobi_mux_credit_arb: NumMaxTrans must be >= 1");
  end

  logic [CntWidth-1:0]    cnt   [NumSbrPorts];
  logic [CntWidth-1:0]    limit [NumSbrPorts];
  logic [NumSbrPorts-1:0] inc, dec, underflow, overflow, elig;
  logic [TotWidth-1:0]    total;
  logic                   any_elig, grant, retire, idx_ok, lock_drop;
  logic [IdxWidth-1:0]    winner, sel, rr_q, rr_d, lock_idx_q, lock_idx_d;
  lock_state_e            lock_q, lock_d;
  logic                   fault_q, fault_d;
  int unsigned            cand;

  assign retire = rsp_valid_i && rsp_ready_i;
  assign idx_ok = (32'(rsp_idx_i) < NumSbrPorts);

  always_comb begin
    total = '0;
    for (int unsigned p = 0; p < NumSbrPorts; p++) begin
      total = total + TotWidth'(cnt[p]);
    end
  end

  for (genvar p = 0; p < NumSbrPorts; p++) begin : g_port
    assign limit[p] = cfg_limit_i[p*CntWidth +: CntWidth];
    assign elig[p]  = sbr_req_i[p] && (cnt[p] < limit[p]) && (total < TotWidth'(NumMaxTrans));
    assign inc[p]   = grant && (sel == IdxWidth'(p));
    assign dec[p]   = retire && idx_ok && (rsp_idx_i == IdxWidth'(p));

    relobi_credit_counter #(
      .CntWidth (CntWidth),
      .MaxVal   (NumMaxTrans)
    ) u_cnt (
      .clk         (clk_i),
      .rst         (rst_i),
      .inc         (inc[p]),
      .dec         (dec[p]),
      .cnt         (cnt[p]),
      .underflow_c (underflow[p]),
      .overflow_c  (overflow[p])
    );

    assign outst_o[p*CntWidth +: CntWidth] = cnt[p];
  end

  // Round-robin search starting at the pointer; first eligible port wins.
  always_comb begin
    any_elig = 1'b0;
    winner   = '0;
    cand     = 0;
    for (int unsigned i = 0; i < NumSbrPorts; i++) begin
      cand = (32'(rr_q) + i) % NumSbrPorts;
      if (!any_elig && elig[IdxWidth'(cand)]) begin
        any_elig = 1'b1;
        winner   = IdxWidth'(cand);
      end
    end
  end

  assign sel       = (lock_q == LOCK_HELD) ? lock_idx_q : winner;
  assign mgr_req_o = !rst_i && (any_elig || (lock_q == LOCK_HELD));
  assign sel_idx_o = rst_i ? '0 : sel;
  assign grant     = mgr_req_o && mgr_gnt_i;

  always_comb begin
    sbr_gnt_o = '0;
    if (grant) sbr_gnt_o[sel] = 1'b1;
  end

  // Lock keeps the request stable toward the manager until it is accepted.
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_d       = rr_q;
    case (lock_q)
      LOCK_IDLE: begin
        if (mgr_req_o && !mgr_gnt_i) begin
          lock_d     = LOCK_HELD;
          lock_idx_d = sel;
        end
      end
      LOCK_HELD: begin
        if (mgr_gnt_i) lock_d = LOCK_IDLE;
      end
      default: lock_d = LOCK_IDLE;
    endcase
    if (grant) rr_d = (sel == IdxWidth'(LastPort)) ? '0 : sel + IdxWidth'(1);
  end

  assign lock_drop = (lock_q == LOCK_HELD) && !sbr_req_i[lock_idx_q];
  assign fault_d   = fault_q || (retire && !idx_ok) || (|underflow) || (|overflow) || lock_drop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q     <= LOCK_IDLE;
      lock_idx_q <= '0;
      rr_q       <= '0;
      fault_q    <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rr_q       <= rr_d;
      fault_q    <= fault_d;
    end
  end

  assign fault_o = fault_q;

endmodule

// File: tb/tb_relobi_mux_credit_arb.sv
// Directed bench for the credit scheduler: grants, lock, round-robin, limits and faults.
module tb_relobi_mux_credit_arb;

  localparam int unsigned N  = 2;
  localparam int unsigned M  = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned IW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*CW-1:0] cfg_limit;
  logic [N-1:0]  sbr_req;
  logic [N-1:0]  sbr_gnt;
  logic          mgr_req;
  logic          mgr_gnt;
  logic [IW-1:0] sel_idx;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [IW-1:0] rsp_idx;
  logic [N*CW-1:0] outst;
  logic          fault;
  logic [CW-1:0] outst0, outst1;

  int checks = 0;
  int errors = 0;

  assign outst0 = outst[2:0];
  assign outst1 = outst[5:3];

  always #5 clk = ~clk;

  relobi_mux_credit_arb #(
    .NumSbrPorts (N),
    .NumMaxTrans (M)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_limit_i (cfg_limit),
    .sbr_req_i   (sbr_req),
    .sbr_gnt_o   (sbr_gnt),
    .mgr_req_o   (mgr_req),
    .mgr_gnt_i   (mgr_gnt),
    .sel_idx_o   (sel_idx),
    .rsp_valid_i (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_idx_i   (rsp_idx),
    .outst_o     (outst),
    .fault_o     (fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sbr_req   = '0;
    mgr_gnt   = 1'b0;
    rsp_valid = 1'b0;
    rsp_idx   = '0;
  endtask

  task automatic retire_one(input logic [IW-1:0] idx);
    idle();
    rsp_valid = 1'b1;
    rsp_idx   = idx;
    tick();
    rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cfg_limit = {3'd2, 3'd2};
    rsp_ready = 1'b1;
    sbr_req   = 2'b11;
    mgr_gnt   = 1'b1;
    rsp_valid = 1'b0;
    rsp_idx   = '0;
    tick();
    tick();
    checks++; if (mgr_req !== 1'b0) begin errors++; $display("FAIL reset_mgr_req got %b exp 0", mgr_req); end
    checks++; if (sbr_gnt !== 2'b00) begin errors++; $display("FAIL reset_sbr_gnt got %b exp 00", sbr_gnt); end
    checks++; if (sel_idx !== 1'b0) begin errors++; $display("FAIL reset_sel got %b exp 0", sel_idx); end
    checks++; if (outst !== 6'd0) begin errors++; $display("FAIL reset_outst got %h exp 0", outst); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fault); end
    idle();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_grant();
    sbr_req = 2'b01;
    mgr_gnt = 1'b1;
    #1;
    checks++; if (sbr_gnt !== 2'b01) begin errors++; $display("FAIL basic_gnt got %b exp 01", sbr_gnt); end
    checks++; if (mgr_req !== 1'b1) begin errors++; $display("FAIL basic_mgr_req got %b exp 1", mgr_req); end
    tick();
    checks++; if (outst0 !== 3'd1) begin errors++; $display("FAIL basic_outst0 got %0d exp 1", outst0); end
    idle();
    rsp_valid = 1'b1;
    rsp_ready = 1'b0;
    tick();
    checks++; if (outst0 !== 3'd1) begin errors++; $display("FAIL basic_no_ready got %0d exp 1", outst0); end
    rsp_ready = 1'b1;
    retire_one(1'b0);
    checks++; if (outst0 !== 3'd0) begin errors++; $display("FAIL basic_retire got %0d exp 0", outst0); end
  endtask

  // Pointer sits at 1 here; a locked port 0 must still win when port 1 joins.
  task automatic test_lock();
    sbr_req = 2'b01;
    mgr_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (sel_idx !== 1'b0) begin errors++; $display("FAIL lock_sel_c%0d got %b exp 0", c, sel_idx); end
      checks++; if (mgr_req !== 1'b1 || sbr_gnt !== 2'b00) begin errors++; $display("FAIL lock_req_c%0d got req %b gnt %b exp req 1 gnt 00", c, mgr_req, sbr_gnt); end
      tick();
    end
    sbr_req = 2'b11;
    mgr_gnt = 1'b1;
    #1;
    checks++; if (sel_idx !== 1'b0) begin errors++; $display("FAIL lock_hold_sel got %b exp 0", sel_idx); end
    checks++; if (sbr_gnt !== 2'b01) begin errors++; $display("FAIL lock_gnt got %b exp 01", sbr_gnt); end
    tick();
    #1;
    checks++; if (sel_idx !== 1'b1 || sbr_gnt !== 2'b10) begin errors++; $display("FAIL lock_rr_next got sel %b gnt %b exp sel 1 gnt 10", sel_idx, sbr_gnt); end
    tick();
    checks++; if (outst0 !== 3'd1 || outst1 !== 3'd1) begin errors++; $display("FAIL lock_outst got %0d/%0d exp 1/1", outst0, outst1); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL lock_fault got %b exp 0", fault); end
    retire_one(1'b0);
    retire_one(1'b1);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    for (int k = 0; k < 4; k++) begin
      sbr_req   = 2'b11;
      mgr_gnt   = 1'b1;
      rsp_valid = (k > 0);
      rsp_idx   = IW'((k + 1) % 2);
      exp_gnt   = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++; if (sbr_gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt_k%0d got %b exp %b", k, sbr_gnt, exp_gnt); end
      tick();
    end
    retire_one(1'b1);
    checks++; if (outst !== 6'd0) begin errors++; $display("FAIL rr_drain got %h exp 0", outst); end
  endtask

  task automatic test_credit_limit();
    cfg_limit = {3'd2, 3'd1};
    sbr_req   = 2'b01;
    mgr_gnt   = 1'b1;
    tick();
    checks++; if (outst0 !== 3'd1) begin errors++; $display("FAIL credit_outst0 got %0d exp 1", outst0); end
    mgr_gnt   = 1'b0;
    rsp_valid = 1'b1;
    rsp_idx   = 1'b0;
    #1;
    checks++; if (mgr_req !== 1'b0) begin errors++; $display("FAIL credit_block got %b exp 0", mgr_req); end
    tick();
    rsp_valid = 1'b0;
    mgr_gnt   = 1'b1;
    #1;
    checks++; if (mgr_req !== 1'b1 || sbr_gnt !== 2'b01) begin errors++; $display("FAIL credit_reopen got req %b gnt %b exp req 1 gnt 01", mgr_req, sbr_gnt); end
    tick();
    retire_one(1'b0);
  endtask

  // Pointer at 1: grants go 1,0,1,0 until the global limit of 4 is hit.
  task automatic test_global_limit();
    logic [1:0] exp_gnt;
    cfg_limit = {3'd3, 3'd3};
    for (int k = 0; k < 4; k++) begin
      sbr_req = 2'b11;
      mgr_gnt = 1'b1;
      exp_gnt = (k % 2 == 0) ? 2'b10 : 2'b01;
      #1;
      checks++; if (sbr_gnt !== exp_gnt) begin errors++; $display("FAIL glob_gnt_k%0d got %b exp %b", k, sbr_gnt, exp_gnt); end
      tick();
    end
    checks++; if (outst0 !== 3'd2 || outst1 !== 3'd2) begin errors++; $display("FAIL glob_outst got %0d/%0d exp 2/2", outst0, outst1); end
    rsp_valid = 1'b1;
    rsp_idx   = 1'b0;
    #1;
    checks++; if (mgr_req !== 1'b0 || sbr_gnt !== 2'b00) begin errors++; $display("FAIL glob_block got req %b gnt %b exp req 0 gnt 00", mgr_req, sbr_gnt); end
    tick();
    sbr_req = 2'b01;
    #1;
    checks++; if (sbr_gnt !== 2'b01) begin errors++; $display("FAIL glob_net_gnt got %b exp 01", sbr_gnt); end
    tick();
    checks++; if (outst0 !== 3'd1 || outst1 !== 3'd2) begin errors++; $display("FAIL glob_net_zero got %0d/%0d exp 1/2", outst0, outst1); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL glob_fault got %b exp 0", fault); end
    retire_one(1'b0);
    retire_one(1'b1);
    retire_one(1'b1);
    checks++; if (outst !== 6'd0) begin errors++; $display("FAIL glob_drain got %h exp 0", outst); end
  endtask

  task automatic test_faults();
    retire_one(1'b1);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL underflow_fault got %b exp 1", fault); end
    checks++; if (outst1 !== 3'd0) begin errors++; $display("FAIL underflow_hold got %0d exp 0", outst1); end
    sbr_req = 2'b01;
    mgr_gnt = 1'b1;
    tick();
    sbr_req = 2'b10;
    mgr_gnt = 1'b0;
    tick();
    #1;
    checks++; if (mgr_req !== 1'b1 || sel_idx !== 1'b1) begin errors++; $display("FAIL midlock_pre got req %b sel %b exp req 1 sel 1", mgr_req, sel_idx); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (mgr_req !== 1'b0 || sel_idx !== 1'b0 || sbr_gnt !== 2'b00) begin errors++; $display("FAIL async_rst_comb got req %b sel %b gnt %b exp 0 0 00", mgr_req, sel_idx, sbr_gnt); end
    checks++; if (outst !== 6'd0 || fault !== 1'b0) begin errors++; $display("FAIL async_rst_regs got outst %h fault %b exp 0 0", outst, fault); end
    idle();
    tick();
    rst = 1'b0;
    tick();
    sbr_req = 2'b01;
    mgr_gnt = 1'b0;
    tick();
    sbr_req = 2'b00;
    #1;
    checks++; if (mgr_req !== 1'b1 || sel_idx !== 1'b0) begin errors++; $display("FAIL drop_hold got req %b sel %b exp req 1 sel 0", mgr_req, sel_idx); end
    tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL drop_fault got %b exp 1", fault); end
    mgr_gnt = 1'b1;
    #1;
    checks++; if (sbr_gnt !== 2'b01) begin errors++; $display("FAIL drop_gnt got %b exp 01", sbr_gnt); end
    tick();
    checks++; if (outst0 !== 3'd1) begin errors++; $display("FAIL drop_counted got %0d exp 1", outst0); end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic_grant();
    test_lock();
    test_round_robin();
    test_credit_limit();
    test_global_limit();
    test_faults();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
